// File: rtl/alu_checker.sv
// Self-checking monitor for the lab-3 ALU: predicts result/zero and compares against the ALU outputs.
// Latency: compares LATENCY edges after issue; cmp_valid/mismatch/counters visible one cycle after that edge.
// Backpressure: none; accepts one op per cycle, and clear drops every in-flight op.
module alu_checker #(
    parameter int LATENCY = 1,
    parameter int CNT_W   = 16
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             issue_valid,
    input  logic [2:0]       opcode,
    input  logic [7:0]       data,
    input  logic [7:0]       accum,
    input  logic [7:0]       alu_out,
    input  logic             zero,
    input  logic             clear,
    output logic             cmp_valid,
    output logic             mismatch,
    output logic [CNT_W-1:0] pass_cnt,
    output logic [CNT_W-1:0] fail_cnt,
    output logic             err_sticky,
    output logic [2:0]       err_opcode,
    output logic [8:0]       err_expected,
    output logic [8:0]       err_actual
);

    typedef struct packed {
        logic [2:0] op;
        logic       zero;
        logic [7:0] res;
    } entry_t;

    localparam logic [CNT_W-1:0] CNT_MAX = '1;
    localparam logic [CNT_W-1:0] CNT_ONE = {{(CNT_W-1){1'b0}}, 1'b1};

    logic [7:0]       a_op;
    logic [7:0]       d_op;
    logic [7:0]       res_exp;
    entry_t           issue_ent;

    logic [LATENCY-1:0] pipe_vld;
    entry_t             pipe_dat [LATENCY];

    entry_t           tail_dat;
    logic             tail_vld;
    logic [8:0]       actual;
    logic             cmp_fail;

    always_comb begin
        a_op    = accum;
        d_op    = data;
        res_exp = 8'h00;
        // MUL only sees the low nibbles of both operands
        if (opcode == 3'b110) begin
            a_op = accum & 8'h0F;
            d_op = data & 8'h0F;
        end
        case (opcode)
            3'b000:  res_exp = a_op;
            3'b001:  res_exp = a_op + d_op;
            3'b010:  res_exp = a_op - d_op;
            3'b011:  res_exp = a_op & d_op;
            3'b100:  res_exp = a_op ^ d_op;
            3'b101:  res_exp = a_op[7] ? (~a_op + 8'd1) : a_op;
            3'b110:  res_exp = {4'h0, a_op[3:0]} * {4'h0, d_op[3:0]};
            default: res_exp = d_op;
        endcase
        issue_ent.op   = opcode;
        issue_ent.res  = res_exp;
        issue_ent.zero = (res_exp == 8'h00);
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            pipe_vld <= '0;
            for (int i = 0; i < LATENCY; i++) begin
                pipe_dat[i] <= '0;
            end
        end else if (clear) begin
            pipe_vld <= '0;
        end else begin
            pipe_vld[0] <= issue_valid;
            pipe_dat[0] <= issue_ent;
            for (int i = 1; i < LATENCY; i++) begin
                pipe_vld[i] <= pipe_vld[i-1];
                pipe_dat[i] <= pipe_dat[i-1];
            end
        end
    end

    assign tail_dat = pipe_dat[LATENCY-1];
    assign tail_vld = pipe_vld[LATENCY-1];
    assign actual   = {zero, alu_out};
    assign cmp_fail = tail_vld && (actual != {tail_dat.zero, tail_dat.res});

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            cmp_valid    <= 1'b0;
            mismatch     <= 1'b0;
            pass_cnt     <= '0;
            fail_cnt     <= '0;
            err_sticky   <= 1'b0;
            err_opcode   <= 3'b000;
            err_expected <= 9'h000;
            err_actual   <= 9'h000;
        end else if (clear) begin
            // clear outranks a comparison landing on the same edge
            cmp_valid    <= 1'b0;
            mismatch     <= 1'b0;
            pass_cnt     <= '0;
            fail_cnt     <= '0;
            err_sticky   <= 1'b0;
            err_opcode   <= 3'b000;
            err_expected <= 9'h000;
            err_actual   <= 9'h000;
        end else begin
            cmp_valid <= tail_vld;
            mismatch  <= cmp_fail;
            if (tail_vld) begin
                if (cmp_fail) begin
                    if (fail_cnt != CNT_MAX) begin
                        fail_cnt <= fail_cnt + CNT_ONE;
                    end
                    if (!err_sticky) begin
                        err_sticky   <= 1'b1;
                        err_opcode   <= tail_dat.op;
                        err_expected <= {tail_dat.zero, tail_dat.res};
                        err_actual   <= actual;
                    end
                end else if (pass_cnt != CNT_MAX) begin
                    pass_cnt <= pass_cnt + CNT_ONE;
                end
            end
        end
    end

endmodule

// File: tb/tb_alu_checker.sv
// Directed bench for alu_checker: a LATENCY=1 instance (narrow counters for saturation)
// and a LATENCY=3 instance for pipelining, clear and mid-flight reset sequences.
module tb_alu_checker;

    typedef struct {
        logic [2:0] op;
        logic [7:0] acc;
        logic [7:0] dat;
        logic [7:0] alu;
        logic       z;
        logic       mis;
    } vec_t;

    logic        clk;
    logic        reset;
    logic [2:0]  opcode;
    logic [7:0]  data;
    logic [7:0]  accum;

    logic        iv1, clr1, z1, cv1, mm1, es1;
    logic [7:0]  alu1;
    logic [3:0]  pc1, fc1;
    logic [2:0]  eo1;
    logic [8:0]  ee1, ea1;

    logic        iv3, clr3, z3, cv3, mm3, es3;
    logic [7:0]  alu3;
    logic [15:0] pc3, fc3;
    logic [2:0]  eo3;
    logic [8:0]  ee3, ea3;

    int n_cmp;
    int n_fail;

    vec_t vt [16];
    int   sched [12];

    alu_checker #(.LATENCY(1), .CNT_W(4)) dut1 (
        .clk(clk), .reset(reset), .issue_valid(iv1), .opcode(opcode), .data(data),
        .accum(accum), .alu_out(alu1), .zero(z1), .clear(clr1),
        .cmp_valid(cv1), .mismatch(mm1), .pass_cnt(pc1), .fail_cnt(fc1),
        .err_sticky(es1), .err_opcode(eo1), .err_expected(ee1), .err_actual(ea1)
    );

    alu_checker #(.LATENCY(3), .CNT_W(16)) dut3 (
        .clk(clk), .reset(reset), .issue_valid(iv3), .opcode(opcode), .data(data),
        .accum(accum), .alu_out(alu3), .zero(z3), .clear(clr3),
        .cmp_valid(cv3), .mismatch(mm3), .pass_cnt(pc3), .fail_cnt(fc3),
        .err_sticky(es3), .err_opcode(eo3), .err_expected(ee3), .err_actual(ea3)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h, want %0h", name, act, exp);
        end
    endtask

    task automatic drive_op(input int idx);
        opcode = vt[idx].op;
        accum  = vt[idx].acc;
        data   = vt[idx].dat;
    endtask

    initial begin
        int exp_pass;
        int exp_fail;
        n_cmp  = 0;
        n_fail = 0;

        //            op      accum  data   alu    z     mis
        vt[0]  = '{3'b011, 8'h00, 8'hA2, 8'h00, 1'b1, 1'b0};
        vt[1]  = '{3'b010, 8'h0F, 8'h1D, 8'hF2, 1'b0, 1'b0};
        vt[2]  = '{3'b001, 8'hFF, 8'h01, 8'h00, 1'b1, 1'b0};
        vt[3]  = '{3'b110, 8'hAB, 8'h3C, 8'h84, 1'b0, 1'b0};
        vt[4]  = '{3'b101, 8'h80, 8'h00, 8'h80, 1'b0, 1'b0};
        vt[5]  = '{3'b101, 8'hF6, 8'h00, 8'h0A, 1'b0, 1'b0};
        vt[6]  = '{3'b000, 8'h5A, 8'h33, 8'h5A, 1'b0, 1'b0};
        vt[7]  = '{3'b100, 8'h5A, 8'hFF, 8'hA5, 1'b0, 1'b0};
        vt[8]  = '{3'b111, 8'h77, 8'h00, 8'h01, 1'b0, 1'b1};
        vt[9]  = '{3'b101, 8'h05, 8'h00, 8'h06, 1'b0, 1'b1};
        vt[10] = '{3'b110, 8'hF7, 8'h3F, 8'h69, 1'b0, 1'b0};
        vt[11] = '{3'b001, 8'h80, 8'h80, 8'h00, 1'b1, 1'b0};
        vt[12] = '{3'b000, 8'h00, 8'hFF, 8'h00, 1'b1, 1'b0};
        vt[13] = '{3'b011, 8'hC3, 8'h3C, 8'h00, 1'b1, 1'b0};
        vt[14] = '{3'b010, 8'h10, 8'h01, 8'h0F, 1'b0, 1'b0};
        vt[15] = '{3'b001, 8'h01, 8'h01, 8'h02, 1'b1, 1'b1};

        // slot schedule for the LATENCY=3 run; -1 marks a bubble
        sched = '{0, 1, 2, -1, 3, 4, 5, -1, 6, 7, 8, 9};

        reset = 1'b0;
        iv1 = 1'b0; clr1 = 1'b0; alu1 = 8'h00; z1 = 1'b0;
        iv3 = 1'b0; clr3 = 1'b0; alu3 = 8'h00; z3 = 1'b0;
        opcode = 3'b000; data = 8'h00; accum = 8'h00;

        repeat (2) @(negedge clk);
        chk("rst cmp_valid", cv1, 0);
        chk("rst mismatch", mm1, 0);
        chk("rst pass_cnt", pc1, 0);
        chk("rst fail_cnt", fc1, 0);
        chk("rst err_sticky", es1, 0);
        chk("rst err_opcode", eo1, 0);
        chk("rst err_expected", ee1, 0);
        chk("rst err_actual", ea1, 0);
        chk("rst l3 cmp_valid", cv3, 0);
        chk("rst l3 pass_cnt", pc3, 0);
        reset = 1'b1;
        @(negedge clk);

        // table-driven single ops through the LATENCY=1 checker
        exp_pass = 0;
        exp_fail = 0;
        for (int i = 0; i < 16; i++) begin
            drive_op(i);
            iv1 = 1'b1;
            @(negedge clk);
            iv1    = 1'b0;
            opcode = 3'($urandom_range(7));
            accum  = 8'($urandom);
            data   = 8'($urandom);
            alu1   = vt[i].alu;
            z1     = vt[i].z;
            chk($sformatf("v%0d early cmp_valid", i), cv1, 0);
            @(negedge clk);
            if (vt[i].mis) exp_fail++;
            else exp_pass++;
            chk($sformatf("v%0d cmp_valid", i), cv1, 1);
            chk($sformatf("v%0d mismatch", i), mm1, vt[i].mis);
            chk($sformatf("v%0d pass_cnt", i), pc1, exp_pass);
            chk($sformatf("v%0d fail_cnt", i), fc1, exp_fail);
            if (i == 8) begin
                chk("first err_sticky", es1, 1);
                chk("first err_opcode", eo1, 3'b111);
                chk("first err_expected", ee1, 9'h100);
                chk("first err_actual", ea1, 9'h001);
            end
        end
        chk("held err_sticky", es1, 1);
        chk("held err_opcode", eo1, 3'b111);
        chk("held err_expected", ee1, 9'h100);
        chk("held err_actual", ea1, 9'h001);

        // saturation: 4 more passes (13 -> 15), then 15 more fails (3 -> 15)
        alu1 = 8'h00; z1 = 1'b1;
        opcode = 3'b000; accum = 8'h00; data = 8'h00;
        for (int j = 0; j < 4; j++) begin
            iv1 = 1'b1;
            if (j >= 2) chk($sformatf("sat pass cmp_valid %0d", j), cv1, 1);
            @(negedge clk);
        end
        iv1 = 1'b0;
        @(negedge clk);
        chk("sat pass_cnt", pc1, 4'hF);
        chk("sat pass mismatch", mm1, 0);
        alu1 = 8'h01; z1 = 1'b0;
        for (int j = 0; j < 15; j++) begin
            iv1 = 1'b1;
            if (j >= 2) chk($sformatf("sat fail mismatch %0d", j), mm1, 1);
            @(negedge clk);
        end
        iv1 = 1'b0;
        @(negedge clk);
        chk("sat fail_cnt", fc1, 4'hF);
        chk("sat fail cmp_valid", cv1, 1);
        chk("sat fail mismatch", mm1, 1);
        chk("sat pass_cnt kept", pc1, 4'hF);

        // LATENCY=3 back-to-back with bubbles: compare exactly 3 edges after issue
        for (int t = 0; t < 16; t++) begin
            if (t < 12 && sched[t] >= 0) begin
                drive_op(sched[t]);
                iv3 = 1'b1;
            end else begin
                opcode = 3'($urandom_range(7));
                accum  = 8'($urandom);
                data   = 8'($urandom);
                iv3    = 1'b0;
            end
            if (t >= 3 && t - 3 < 12 && sched[t-3] >= 0) begin
                alu3 = vt[sched[t-3]].alu;
                z3   = vt[sched[t-3]].z;
            end else begin
                alu3 = 8'($urandom);
                z3   = 1'($urandom);
            end
            if (t >= 4) begin
                chk($sformatf("pipe t%0d cmp_valid", t), cv3, (sched[t-4] >= 0) ? 1 : 0);
                chk($sformatf("pipe t%0d mismatch", t), mm3,
                    (sched[t-4] >= 0) ? vt[sched[t-4]].mis : 1'b0);
            end else begin
                chk($sformatf("pipe t%0d cmp_valid", t), cv3, 0);
            end
            @(negedge clk);
        end
        chk("pipe pass_cnt", pc3, 8);
        chk("pipe fail_cnt", fc3, 2);
        chk("pipe err_opcode", eo3, 3'b111);
        chk("pipe err_actual", ea3, 9'h001);

        // clear with 3 ops in flight plus one issued on the clear edge; next op tracked
        for (int t = 0; t < 10; t++) begin
            clr3 = (t == 3);
            iv3  = (t <= 4);
            if (t <= 3) drive_op(t);
            else drive_op(6);
            alu3 = (t == 7) ? 8'h5A : 8'h55;
            z3   = 1'b0;
            if (t >= 1) begin
                chk($sformatf("clr t%0d cmp_valid", t), cv3, (t == 8) ? 1 : 0);
                chk($sformatf("clr t%0d mismatch", t), mm3, 0);
            end
            if (t == 4) begin
                chk("clr pass_cnt", pc3, 0);
                chk("clr fail_cnt", fc3, 0);
                chk("clr err_sticky", es3, 0);
                chk("clr err_opcode", eo3, 0);
                chk("clr err_expected", ee3, 0);
                chk("clr err_actual", ea3, 0);
            end
            @(negedge clk);
        end
        clr3 = 1'b0;
        iv3  = 1'b0;
        chk("post-clr pass_cnt", pc3, 1);
        chk("post-clr fail_cnt", fc3, 0);

        // mid-flight reset: one fault lands, then reset drops the rest
        for (int t = 0; t < 11; t++) begin
            iv3 = (t <= 3);
            if (t == 0) drive_op(8);
            else if (t <= 3) drive_op(t - 1);
            alu3 = 8'h01;
            z3   = 1'b0;
            if (t == 4) begin
                chk("prerst mismatch", mm3, 1);
                chk("prerst fail_cnt", fc3, 1);
                chk("prerst err_sticky", es3, 1);
                reset = 1'b0;
                #1;
                chk("async rst cmp_valid", cv3, 0);
                chk("async rst mismatch", mm3, 0);
                chk("async rst pass_cnt", pc3, 0);
                chk("async rst fail_cnt", fc3, 0);
                chk("async rst err_sticky", es3, 0);
                chk("async rst err_expected", ee3, 0);
                #1;
                reset = 1'b1;
            end else if (t > 4) begin
                chk($sformatf("rst t%0d cmp_valid", t), cv3, 0);
            end
            @(negedge clk);
        end
        chk("post-rst pass_cnt", pc3, 0);
        chk("post-rst fail_cnt", fc3, 0);
        chk("post-rst err_actual", ea3, 0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule

// File: doc/alu_checker.md
# alu_checker

Hardware self-checking monitor for the lab-3 ALU. It sits beside the ALU and watches the same operand/opcode bus that drives it. For every issued operation it computes the expected result and zero flag, waits the ALU's pipeline latency, and compares against the ALU outputs. It keeps pass/fail counts and latches the first mismatch, so a bench or an on-board LED/7-seg path can report results without a simulator log.

## Interface

- `LATENCY`, default 1: ALU result latency in clock cycles; legal range 1..4.
- `CNT_W`, default 16: width of the pass/fail counters.

Ports:

- `clk`  in  1: single clock; all state changes on the rising edge.
- `reset`  in  1: asynchronous, active-low reset.
- `issue_valid`  in  1: an ALU operation is presented this cycle.
- `opcode`  in  3: ALU opcode.
  - 000 PASSA, 001 ADD, 010 SUB, 011 AND, 100 XOR, 101 ABS, 110 MUL, 111 PASSD.
- `data`  in  8: data operand, unmasked.
- `accum`  in  8: accumulator operand, unmasked.
- `alu_out`  in  8: ALU result.
- `zero`  in  1: ALU zero flag.
- `clear`  in  1: synchronous clear of counters, error capture and in-flight ops.
- `cmp_valid`  out  1: one-cycle pulse; a comparison occurred at this edge.
- `mismatch`  out  1: one-cycle pulse with `cmp_valid`; that comparison failed.
- `pass_cnt`  out  CNT_W: number of passing comparisons, saturating.
- `fail_cnt`  out  CNT_W: number of failing comparisons, saturating.
- `err_sticky`  out  1: set on the first mismatch; held until `clear` or reset.
- `err_opcode`  out  3: opcode of the first mismatching op.
- `err_expected`  out  9: `{zero_exp, result_exp}` of the first mismatch.
- `err_actual`  out  9: `{zero, alu_out}` of the first mismatch.

## Operation

- **Operand masking:** when `opcode == 110`, both operands are masked with 8'h0F before use. All other opcodes use the full 8 bits.
- **Expected result (8 bits, modulo 256):**
  - PASSA = accum
  - ADD = accum + data
  - SUB = accum − data
  - AND = accum & data
  - XOR = accum ^ data
  - ABS = accum[7] ? −accum : accum, so 8'h80 yields 8'h80
  - MUL = accum[3:0] × data[3:0], 8-bit product
  - PASSD = data
- **Expected zero flag:** `zero_exp = (result_exp == 8'h00)`.
- **Issue sampling:** when `issue_valid` is sampled high, the checker pushes `{opcode, result_exp, zero_exp}` into a LATENCY-stage shift pipeline. Each stage carries its own valid bit. Bubbles (`issue_valid` low) travel as invalid stages.
- **Comparison:** when a valid entry reaches the pipeline end, the checker compares it with the current `alu_out`/`zero`.
  - Match: `pass_cnt` increments.
  - Mismatch: `fail_cnt` increments.
  - Both counters saturate at all-ones.
- **First-mismatch capture:** on a mismatch with `err_sticky` low, `err_sticky` is set and `err_opcode`/`err_expected`/`err_actual` are captured. Later mismatches count but never overwrite the capture.
- **Back-to-back issue:** one op per cycle is supported with no throughput loss.
- **`clear`:** zeroes both counters, `err_*` and all pipeline valid bits. In-flight ops are dropped and never compared.

## Timing

- **Reset values:** while `reset` is low, every output is 0 and all pipeline valid bits are 0. Reset takes effect immediately (asynchronous). Release is synchronous to the next rising edge.
- **Comparison edge:** an op issued at edge k is compared at edge k+LATENCY.
- **Output visibility:** `cmp_valid`/`mismatch` are registered and high during the cycle after edge k+LATENCY. Counter and `err_*` updates become visible at the same point.
- **`clear` priority:** `clear` at edge c wins over any comparison at edge c; no count is recorded. An op issued at edge c with `clear` high is also dropped. Issues from edge c+1 onward are tracked normally.
- **Reset mid-operation:** all pending ops are discarded. No comparison fires for ops issued before reset.
- **Saturation:** a counter at all-ones stays at all-ones. `mismatch`/`cmp_valid` still pulse.
- **Operand don't-cares:** `opcode`/`data`/`accum` are ignored when `issue_valid` is low.

## Test plan

- **Reset and AND:** hold reset low 2 cycles, then release; all outputs are 0. Issue AND, accum 8'h00, data 8'hA2, with a correct ALU. Expected {1, 8'h00}; `cmp_valid` pulses at k+1; `pass_cnt` = 1.
- **SUB and ADD wrap:** SUB 8'h0F − 8'h1D expects 8'hF2, zero 0. Then ADD 8'hFF + 8'h01 expects 8'h00, zero 1. `pass_cnt` = 2.
- **MUL masking and ABS:** MUL with accum 8'hAB, data 8'h3C expects 8'h84 (B×C). ABS with accum 8'h80 expects 8'h80; accum 8'hF6 expects 8'h0A.
- **Injected faults:** force `alu_out` = 8'h01 on a PASSD data 8'h00 op. Result: `mismatch` pulses, `fail_cnt` = 1, `err_sticky` = 1, `err_opcode` = 111, `err_expected` = 9'h100, `err_actual` = 9'h001. A second fault bumps `fail_cnt` to 2; the capture is unchanged.
- **Pipelining:** with LATENCY = 3, issue 10 back-to-back random ops with two bubbles inserted. Ten comparisons occur, each exactly 3 edges after its issue, and none occur in bubble slots.
- **Clear and mid-flight reset:** with LATENCY = 3, issue 3 ops, then assert `clear` on the next edge. No comparisons follow; counters and `err_*` read 0. Repeat with `reset` pulsed low mid-flight; the behaviour is identical.
